// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_op_e;

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder slice: sum, carry out, and carry into the MSB.
module adder_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // The sum bit at the MSB is a ^ b ^ carry_in, so the carry into it falls out directly.
    assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into STAGES registered slices,
// with valid/ready handshake, global stall enable and registered carry/overflow/zero flags.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK       = WIDTH / SAFE_STAGES;

    if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_params
        $fatal(1, "pipelined_adder: WIDTH must be divisible by STAGES and STAGES >= 1");
    end

    adder_op_e        op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic             en;

    // Per-stage registers; a_q/b_q carry the not-yet-added upper operand chunks forward.
    logic [WIDTH-1:0] a_q   [SAFE_STAGES];
    logic [WIDTH-1:0] b_q   [SAFE_STAGES];
    logic [WIDTH-1:0] r_q   [SAFE_STAGES];
    logic             c_q   [SAFE_STAGES];
    logic             v_q   [SAFE_STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [CHUNK-1:0] sum_w  [SAFE_STAGES];
    logic             cout_w [SAFE_STAGES];
    logic             cmsb_w [SAFE_STAGES];

    assign op     = adder_op_e'(in_op);
    assign is_sub = (op == SUB);
    assign b_eff  = in_b ^ {WIDTH{is_sub}};

    assign out_valid    = v_q[SAFE_STAGES-1];
    assign en           = !(out_valid && !out_ready);
    assign in_ready     = en;
    assign out_result   = r_q[SAFE_STAGES-1];
    assign out_carry    = c_q[SAFE_STAGES-1];
    assign out_overflow = ovf_q;
    assign out_zero     = zero_q;

    for (genvar k = 0; k < SAFE_STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] a_ch;
        logic [CHUNK-1:0] b_ch;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] r_in;
        logic [WIDTH-1:0] r_next;

        if (k == 0) begin : g_first
            assign a_ch = in_a[k*CHUNK +: CHUNK];
            assign b_ch = b_eff[k*CHUNK +: CHUNK];
            assign c_in = is_sub;
            assign v_in = in_valid;
            assign r_in = '0;
        end else begin : g_next
            assign a_ch = a_q[k-1][k*CHUNK +: CHUNK];
            assign b_ch = b_q[k-1][k*CHUNK +: CHUNK];
            assign c_in = c_q[k-1];
            assign v_in = v_q[k-1];
            assign r_in = r_q[k-1];
        end

        adder_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a   (a_ch),
            .b   (b_ch),
            .cin (c_in),
            .sum (sum_w[k]),
            .cout(cout_w[k]),
            .cmsb(cmsb_w[k])
        );

        always_comb begin
            r_next                     = r_in;
            r_next[k*CHUNK +: CHUNK]   = sum_w[k];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k] <= v_in;
                r_q[k] <= r_next;
                c_q[k] <= cout_w[k];
            end
        end

        if (k < SAFE_STAGES - 1) begin : g_skew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (en) begin
                    if (k == 0) begin
                        a_q[k] <= in_a;
                        b_q[k] <= b_eff;
                    end else begin
                        a_q[k] <= a_q[k-1];
                        b_q[k] <= b_q[k-1];
                    end
                end
            end
        end else begin : g_flags
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= cmsb_w[k] ^ cout_w[k];
                    zero_q <= (r_next == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases, stall/reset scenarios and a
// randomized sweep of three configurations against an arithmetic reference model.
module tb_pipelined_adder;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    typedef struct {
        int   due;
        res_t e;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: WIDTH=32, STAGES=2
    logic        in_valid = 1'b0, in_ready, in_op = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        out_valid, out_ready = 1'b1, out_carry, out_overflow, out_zero;
    logic [31:0] out_result;

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_overflow(out_overflow), .out_zero(out_zero)
    );

    // Sweep DUTs share stimulus; consumers always ready.
    logic        sv_valid = 1'b0, sv_op = 1'b0, sv_ready = 1'b1;
    logic [63:0] sv_a = '0, sv_b = '0;

    logic        d1_in_ready, d1_valid, d1_c, d1_v, d1_z;
    logic [31:0] d1_r;
    logic        d4_in_ready, d4_valid, d4_c, d4_v, d4_z;
    logic [63:0] d4_r;

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv_valid), .in_ready(d1_in_ready), .in_a(sv_a[31:0]), .in_b(sv_b[31:0]), .in_op(sv_op),
        .out_valid(d1_valid), .out_ready(sv_ready), .out_result(d1_r),
        .out_carry(d1_c), .out_overflow(d1_v), .out_zero(d1_z)
    );

    pipelined_adder #(.WIDTH(64), .STAGES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sv_valid), .in_ready(d4_in_ready), .in_a(sv_a), .in_b(sv_b), .in_op(sv_op),
        .out_valid(d4_valid), .out_ready(sv_ready), .out_result(d4_r),
        .out_carry(d4_c), .out_overflow(d4_v), .out_zero(d4_z)
    );

    // Reference: plain modular arithmetic and signed-range reasoning on w-bit values.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic op, input int w);
        res_t        m;
        logic [64:0] mask, a_, b_, s;
        logic        sa, sb, sr;
        mask = (65'd1 << w) - 65'd1;
        a_   = {1'b0, a} & mask;
        b_   = {1'b0, b} & mask;
        if (!op) begin
            s   = a_ + b_;
            m.c = s[w];
        end else begin
            s   = a_ - b_;
            m.c = (a_ >= b_);
        end
        m.r = s[63:0] & mask[63:0];
        sa  = a_[w-1];
        sb  = b_[w-1];
        sr  = m.r[w-1];
        m.v = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        m.z = (m.r == 64'd0);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic one_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] er, input logic ec, input logic ev, input logic ez);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({tag, "_early_valid"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_result"}, out_result, er);
        chk({tag, "_carry"}, out_carry, ec);
        chk({tag, "_ovf"}, out_overflow, ev);
        chk({tag, "_zero"}, out_zero, ez);
    endtask

    // rnd=0: continuous input, consumer stalls for cycles 3..5; rnd=1: random valid/ready.
    task automatic stream(input int n, input bit rnd);
        exp_t        q[$];
        exp_t        item;
        int          sent = 0, got = 0, cyc = 0;
        bit          was_stalled = 0;
        logic [31:0] held = '0;
        while (got < n && cyc < n * 20 + 50) begin
            @(negedge clk);
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc < 6);
            if (sent < n) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
                in_op    = $urandom_range(0, 1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (was_stalled) chk("stall_hold", out_result, held);
            chk("stall_in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                chk("stream_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    item = q.pop_front();
                    chk("stream_result", out_result, item.e.r);
                    chk("stream_carry", out_carry, item.e.c);
                    chk("stream_ovf", out_overflow, item.e.v);
                    chk("stream_zero", out_zero, item.e.z);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                item.due = 0;
                item.e   = model({32'd0, in_a}, {32'd0, in_b}, in_op, 32);
                q.push_back(item);
                sent++;
            end
            was_stalled = out_valid && !out_ready;
            held        = out_result;
            cyc++;
        end
        chk("stream_count", got, n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("stream_no_extra", out_valid, 0);
        end
    endtask

    initial begin
        exp_t q1[$], q4[$];
        exp_t it;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_carry", out_carry, 0);
        chk("rst_ovf", out_overflow, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_s4_valid", d4_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", in_ready, 1);

        // Directed arithmetic
        one_op("add_boundary", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 0, 0, 0);
        one_op("sub_equal", 32'd5, 32'd5, 1'b1, 32'h0000_0000, 1, 0, 1);
        one_op("sub_borrow", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        one_op("add_sovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 0, 1, 0);
        one_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1, 0, 1);

        // Backpressure
        stream(4, 1'b0);
        stream(200, 1'b1);

        // Asynchronous reset with two transactions in flight
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd2; in_op = 1'b0;
        @(negedge clk);
        in_a = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("inflight_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_result", out_result, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1 chk("no_stale_after_rst", out_valid, 0);
        end

        // Randomized sweep: STAGES=1 (32b) and STAGES=4 (64b), exact latency
        for (int i = 0; i < 1008; i++) begin
            @(negedge clk);
            #1;
            chk("s1_in_ready", d1_in_ready, 1);
            chk("s4_in_ready", d4_in_ready, 1);
            if (q1.size() != 0 && q1[0].due == i) begin
                it = q1.pop_front();
                chk("s1_valid", d1_valid, 1);
                chk("s1_result", {32'd0, d1_r}, it.e.r);
                chk("s1_flags", {d1_c, d1_v, d1_z}, {it.e.c, it.e.v, it.e.z});
            end else begin
                chk("s1_idle", d1_valid, 0);
            end
            if (q4.size() != 0 && q4[0].due == i) begin
                it = q4.pop_front();
                chk("s4_valid", d4_valid, 1);
                chk("s4_result", d4_r, it.e.r);
                chk("s4_flags", {d4_c, d4_v, d4_z}, {it.e.c, it.e.v, it.e.z});
            end else begin
                chk("s4_idle", d4_valid, 0);
            end
            sv_valid = (i < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            sv_a     = {$urandom, $urandom};
            sv_b     = ($urandom_range(0, 7) == 0) ? sv_a : {$urandom, $urandom};
            sv_op    = $urandom_range(0, 1);
            if (sv_valid) begin
                it.due = i + 1;
                it.e   = model(sv_a, sv_b, sv_op, 32);
                q1.push_back(it);
                it.due = i + 4;
                it.e   = model(sv_a, sv_b, sv_op, 64);
                q4.push_back(it);
            end
        end
        chk("s1_drained", q1.size(), 0);
        chk("s4_drained", q4.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
